ula_seq: RTL
============

Name: ula_seq

Overview:
Parametrised, registered successor of the team's 4-bit combinational ULA.
- Operand width is generic (WIDTH); adds XOR and a multi-cycle shift-add multiply.
- Adds status flags (zero, negativo, carry, overflow) and valid/ready handshakes on input and output.
- Sits between the operand register file and the writeback stage of the SD122 datapath; one operation in flight at a time.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
A  input  WIDTH  operand A
B  input  WIDTH  operand B
seletor  input  3  operation select
in_valid  input  1  A/B/seletor valid this cycle
in_ready  output  1  block can accept an operation
resultado  output  WIDTH  result (low WIDTH bits for MUL)
resultado_alto  output  WIDTH  high WIDTH bits of MUL product; 0 for other ops
zero  output  1  resultado == 0
negativo  output  1  resultado[WIDTH-1]
carry  output  1  ADD carry-out / SUB borrow / MUL high half nonzero
overflow  output  1  signed overflow (ADD/SUB only)
out_valid  output  1  resultado and flags valid
out_ready  input  1  downstream accepts result

Behaviour:
- Reset (rst_n=0 at clk edge): state=OCIOSO; in_ready=1; out_valid=0; resultado, resultado_alto, zero, negativo, carry, overflow all 0. Reset overrides any operation in progress, including mid-MUL and pending output; the partial product is discarded.
- Handshake rules:
  - Input transfer when in_valid && in_ready. A, B and seletor are captured on that edge; input changes afterwards have no effect.
  - Output transfer when out_valid && out_ready. Outputs stay stable while out_valid=1 and out_ready=0.
- FSM:
  - OCIOSO: in_ready=1, out_valid=0.
    - Accept with seletor!=110 → compute, register outputs, go to SAIDA (latency 1: out_valid high the cycle after acceptance).
    - Accept with seletor=110 → go to MULT.
  - MULT: in_ready=0. Shift-add, one multiplier bit per cycle, counter WIDTH-1 down to 0. After WIDTH cycles, register the product and go to SAIDA (out_valid high WIDTH+1 cycles after acceptance).
  - SAIDA: in_ready=0, out_valid=1. On out_ready=1 go to OCIOSO; out_valid drops the next cycle.
  - No back-to-back accept: minimum 2 cycles per single-cycle op. A new in_valid while in MULT/SAIDA is ignored (in_ready=0).
- Operations (unsigned, results truncated to WIDTH):
  - 000 AND; 001 OR; 010 NOT A; 011 NAND; 111 XOR → carry=0, overflow=0.
  - 100 ADD: carry = bit WIDTH of A+B; overflow = (A,B same sign) && (result sign differs).
  - 101 SUB: A-B mod 2^WIDTH; carry = borrow (A<B unsigned); overflow = (A,B signs differ) && (result sign != A sign).
  - 110 MUL: unsigned 2*WIDTH product; {resultado_alto,resultado}; carry = (resultado_alto!=0); overflow=0.
- Flags for all ops: zero and negativo are computed from resultado only. resultado_alto=0 for every op except MUL.
- Flags are registered together with resultado and updated only when entering SAIDA.

Optional Feature:
- Macro ULA_SEQ_MULT_EN.
- Defined: MUL and state MULT are implemented as above.
- Undefined: MULT state and multiplier hardware are not built. seletor=110 completes in 1 cycle like a logic op, with resultado=0, resultado_alto=0, zero=1, negativo=0, carry=0, overflow=0.

Test Plan:
- Reset: rst_n=0 two cycles → in_ready=1, out_valid=0, all outputs 0.
- ADD, WIDTH=8: A=0x7F, B=0x01, seletor=100 → next cycle out_valid=1, resultado=0x80, negativo=1, overflow=1, carry=0, zero=0. Repeat with A=0xFF, B=0x01 → resultado=0x00, zero=1, carry=1, overflow=0.
- SUB: A=0x03, B=0x05, seletor=101 → resultado=0xFE, carry=1, negativo=1, overflow=0.
- MUL (macro defined): A=0xFF, B=0xFF, seletor=110 → in_ready=0 for 9 cycles, out_valid at acceptance+9, resultado_alto=0xFE, resultado=0x01, carry=1. Undefined → resultado=0, zero=1 at acceptance+1.
- Backpressure: result pending with out_ready=0 for 5 cycles and in_valid=1 with new operands → outputs unchanged, in_ready=0; out_ready=1 → OCIOSO next cycle, then new op accepted.
- Reset mid-MUL: rst_n=0 at cycle 4 of MULT → next cycle state OCIOSO, out_valid=0, resultado=0; no stale result ever appears.

Source files
------------

// File: rtl/ula_seq.sv
// Registered ULA with valid/ready handshakes, status flags and an optional shift-add multiplier.
// Define ULA_SEQ_MULT_EN to build the MULT state and multiplier; otherwise seletor=110 yields zero in one cycle.
module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       seletor,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resultado_alto,
  output logic             zero,
  output logic             negativo,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  // state  | meaning
  // OCIOSO | idle, accepting an operation
  // MULT   | shift-add multiply in progress
  // SAIDA  | result and flags held until out_ready

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    MULT   = 2'd1,
    SAIDA  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic             accept;
  logic             is_mul;
  logic             mult_done;
  logic             load;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] nx_res;
  logic [WIDTH-1:0] nx_alto;
  logic             nx_c;
  logic             nx_v;

  assign accept = (state == OCIOSO) && in_valid;

`ifdef ULA_SEQ_MULT_EN
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   prod;
  logic [CW-1:0]      cnt;
  logic               fin;
  logic [WIDTH:0]     psum;

  assign is_mul    = (seletor == OP_MUL);
  assign mult_done = fin;
  // Upper half accumulates the multiplicand whenever the current multiplier bit is set.
  assign psum      = prod[2*WIDTH:WIDTH] + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
`else
  assign is_mul    = 1'b0;
  assign mult_done = 1'b0;
`endif

  assign load = (accept && !is_mul) || ((state == MULT) && mult_done);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= OCIOSO;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      OCIOSO: if (in_valid) state_nx = is_mul ? MULT : SAIDA;
`ifdef ULA_SEQ_MULT_EN
      MULT:   if (mult_done) state_nx = SAIDA;
`endif
      SAIDA:  if (out_ready) state_nx = OCIOSO;
      default: state_nx = OCIOSO;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      OCIOSO:  in_ready  = 1'b1;
      SAIDA:   out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    add_w   = {1'b0, A} + {1'b0, B};
    sub_w   = {1'b0, A} - {1'b0, B};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (seletor)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NOT:  alu_res = ~A;
      OP_NAND: alu_res = ~(A & B);
      OP_XOR:  alu_res = A ^ B;
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      default: ;
    endcase
  end

  always_comb begin
    nx_res  = alu_res;
    nx_alto = '0;
    nx_c    = alu_c;
    nx_v    = alu_v;
`ifdef ULA_SEQ_MULT_EN
    if (state == MULT) begin
      nx_res  = prod[WIDTH-1:0];
      nx_alto = prod[2*WIDTH-1:WIDTH];
      nx_c    = |prod[2*WIDTH-1:WIDTH];
      nx_v    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resultado      <= '0;
      resultado_alto <= '0;
      zero           <= 1'b0;
      negativo       <= 1'b0;
      carry          <= 1'b0;
      overflow       <= 1'b0;
    end else if (load) begin
      resultado      <= nx_res;
      resultado_alto <= nx_alto;
      zero           <= (nx_res == '0);
      negativo       <= nx_res[WIDTH-1];
      carry          <= nx_c;
      overflow       <= nx_v;
    end
  end

`ifdef ULA_SEQ_MULT_EN
  // One extra MULT cycle after the last step is spent registering the product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
      fin   <= 1'b0;
    end else if (accept && is_mul) begin
      mcand <= A;
      prod  <= {{(WIDTH+1){1'b0}}, B};
      cnt   <= CW'(WIDTH-1);
      fin   <= 1'b0;
    end else if ((state == MULT) && !fin) begin
      prod <= {1'b0, psum, prod[WIDTH-1:1]};
      if (cnt == '0) fin <= 1'b1;
      else           cnt <= cnt - 1'b1;
    end
  end
`endif

endmodule
